pixel_capture: RTL and testbench

PIXEL_CAPTURE -- requirements
Module: pixel_capture

---
 rtl/pixel_capture_pkg.sv | 30 +++
 rtl/pixel_capture_addr_calc.sv | 57 +++++
 rtl/pixel_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_pixel_capture.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_capture_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_capture_pkg : shared states, sprite layout and LCD limits  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package pixel_capture_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    READY    = 4'd1,
    HEADER_W = 4'd2,
    HEADER_H = 4'd3,
    CLEAR    = 4'd4,
    ARMED    = 4'd5,
    ACCEPT   = 4'd6,
    STORE    = 4'd7,
    DONE     = 4'd8
  } state_t;

  // Sprite layout: word 0 = width, word 1 = height, pixels follow.
  localparam logic [15:0] HDR_WORDS  = 16'd2;
  localparam int          LCD_WIDTH  = 240;
  localparam int          LCD_HEIGHT = 320;

  function automatic logic [16:0] sprite_area(input logic [7:0] w, input logic [8:0] h);
    return {9'd0, w} * {8'd0, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_capture_addr_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_addr_calc : registered window test and sprite address     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module sprite_addr_calc
  import pixel_capture_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  x,
  input  logic [8:0]  y,
  input  logic [7:0]  x_origin,
  input  logic [8:0]  y_origin,
  input  logic [7:0]  width,
  input  logic [8:0]  height,
  output logic [15:0] addr,
  output logic        in_window
);

  logic [7:0]  dx;
  logic [8:0]  dy;
  logic [15:0] prod;
  logic        x_ok;
  logic        y_ok;
  logic [15:0] addr_d;
  logic [15:0] addr_q;
  logic        in_window_d;
  logic        in_window_q;

  // Upper bounds are widened by one bit so origin+size never wraps.
  always_comb begin
    dx          = x - x_origin;
    dy          = y - y_origin;
    prod        = {7'd0, dy} * {8'd0, width};
    x_ok        = (x >= x_origin) && ({1'b0, x} < ({1'b0, x_origin} + {1'b0, width}));
    y_ok        = (y >= y_origin) && ({1'b0, y} < ({1'b0, y_origin} + {1'b0, height}));
    in_window_d = x_ok && y_ok;
    addr_d      = HDR_WORDS + prod + {8'd0, dx};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= 16'd0;
      in_window_q <= 1'b0;
    end else if (en) begin
      addr_q      <= addr_d;
      in_window_q <= in_window_d;
    end
  end

  assign addr      = addr_q;
  assign in_window = in_window_q;

endmodule
`default_nettype wire

// File: rtl/pixel_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_capture : pixel-write responder storing a sprite into RAM  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module pixel_capture
  import pixel_capture_pkg::*;
#(
  parameter int          RAM_DEPTH   = 65536,
  parameter logic [15:0] TRANSPARENT = 16'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xOrigin,
  input  logic [8:0]  yOrigin,
  input  logic [7:0]  imgWidth,
  input  logic [8:0]  imgHeight,
  input  logic        arm,
  input  logic        finish,
  output logic        ready,
  output logic        done,
  output logic        error,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic [15:0] ramAddr,
  output logic [15:0] ramData,
  output logic        ramWrite
);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        pix_ready_q, pix_ready_d;
  logic        ram_write_q, ram_write_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_data_q, ram_data_d;
  logic [7:0]  x_origin_q, x_origin_d;
  logic [8:0]  y_origin_q, y_origin_d;
  logic [7:0]  width_q, width_d;
  logic [8:0]  height_q, height_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pw_prev_q;
  logic        fin_pend_q, fin_pend_d;

  logic [16:0] area;
  logic        size_ok;
  logic        accept;
  logic [15:0] calc_addr;
  logic        calc_in_window;

  always_comb begin
    area    = sprite_area(imgWidth, imgHeight);
    size_ok = (imgWidth != 8'd0) && (imgHeight != 9'd0) &&
              (({15'd0, area} + 32'd2) <= 32'(RAM_DEPTH));
  end

  // Only a rising edge of pixelWrite while pixelReady is high is taken.
  assign accept = (state_q == ARMED) && pix_ready_q && pixelWrite && !pw_prev_q;

  sprite_addr_calc u_addr_calc (
    .clock     (clock),
    .reset     (reset),
    .en        (accept),
    .x         (xAddr),
    .y         (yAddr),
    .x_origin  (x_origin_q),
    .y_origin  (y_origin_q),
    .width     (width_q),
    .height    (height_q),
    .addr      (calc_addr),
    .in_window (calc_in_window)
  );

  always_comb begin
    state_d     = state_q;
    error_d     = error_q;
    x_origin_d  = x_origin_q;
    y_origin_d  = y_origin_q;
    width_d     = width_q;
    height_d    = height_q;
    last_addr_d = last_addr_q;
    pix_data_d  = pix_data_q;
    fin_pend_d  = fin_pend_q;

    case (state_q)
      IDLE: begin
        error_d    = 1'b0;
        fin_pend_d = 1'b0;
        if (!arm) state_d = READY;
      end
      READY: begin
        if (arm) begin
          x_origin_d  = xOrigin;
          y_origin_d  = yOrigin;
          width_d     = imgWidth;
          height_d    = imgHeight;
          last_addr_d = area[15:0] + 16'd1;
          if (size_ok) begin
            state_d = HEADER_W;
            error_d = 1'b0;
          end else begin
            state_d = DONE;
            error_d = 1'b1;
          end
        end
      end
      HEADER_W: state_d = HEADER_H;
      HEADER_H: state_d = CLEAR;
      CLEAR: begin
        if (ram_addr_q == last_addr_q) state_d = ARMED;
      end
      ARMED: begin
        if (accept) begin
          state_d    = ACCEPT;
          pix_data_d = pixelData;
          if (finish) fin_pend_d = 1'b1;
        end else if (finish || fin_pend_q) begin
          state_d = DONE;
        end
      end
      ACCEPT: begin
        state_d = STORE;
        if (finish) fin_pend_d = 1'b1;
      end
      STORE: begin
        state_d = ARMED;
        if (finish) fin_pend_d = 1'b1;
      end
      DONE: begin
        if (!arm && !finish) begin
          state_d    = IDLE;
          error_d    = 1'b0;
          fin_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    ready_d     = 1'b0;
    done_d      = 1'b0;
    pix_ready_d = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    case (state_d)
      READY:    ready_d = 1'b1;
      HEADER_W: begin
        ram_write_d = 1'b1;
        ram_addr_d  = 16'd0;
        ram_data_d  = {8'd0, width_d};
      end
      HEADER_H: begin
        ram_write_d = 1'b1;
        ram_addr_d  = 16'd1;
        ram_data_d  = {7'd0, height_q};
      end
      CLEAR: begin
        ram_write_d = 1'b1;
        ram_addr_d  = (state_q == CLEAR) ? (ram_addr_q + 16'd1) : HDR_WORDS;
        ram_data_d  = TRANSPARENT;
      end
      // A settle cycle after STORE makes the handshake turnaround three cycles.
      ARMED:    pix_ready_d = (state_q != STORE);
      STORE: begin
        if (calc_in_window) begin
          ram_write_d = 1'b1;
          ram_addr_d  = calc_addr;
          ram_data_d  = pix_data_q;
        end
      end
      DONE:     done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pix_ready_q <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= 16'd0;
      ram_data_q  <= 16'd0;
      x_origin_q  <= 8'd0;
      y_origin_q  <= 9'd0;
      width_q     <= 8'd0;
      height_q    <= 9'd0;
      last_addr_q <= 16'd0;
      pix_data_q  <= 16'd0;
      pw_prev_q   <= 1'b0;
      fin_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      pix_ready_q <= pix_ready_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      x_origin_q  <= x_origin_d;
      y_origin_q  <= y_origin_d;
      width_q     <= width_d;
      height_q    <= height_d;
      last_addr_q <= last_addr_d;
      pix_data_q  <= pix_data_d;
      pw_prev_q   <= pixelWrite;
      fin_pend_q  <= fin_pend_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign error      = error_q;
  assign pixelReady = pix_ready_q;
  assign ramWrite   = ram_write_q;
  assign ramAddr    = ram_addr_q;
  assign ramData    = ram_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pixel_capture : scoreboard bench for pixel_capture            |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_pixel_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  xOrigin;
  logic [8:0]  yOrigin;
  logic [7:0]  imgWidth;
  logic [8:0]  imgHeight;
  logic        arm;
  logic        finish;
  logic        ready;
  logic        done;
  logic        error;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic [15:0] ramAddr;
  logic [15:0] ramData;
  logic        ramWrite;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  pixel_capture dut (
    .clock      (clock),
    .reset      (reset),
    .xOrigin    (xOrigin),
    .yOrigin    (yOrigin),
    .imgWidth   (imgWidth),
    .imgHeight  (imgHeight),
    .arm        (arm),
    .finish     (finish),
    .ready      (ready),
    .done       (done),
    .error      (error),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady),
    .ramAddr    (ramAddr),
    .ramData    (ramData),
    .ramWrite   (ramWrite)
  );

  always #5 clock = ~clock;

  // Every RAM write must match the next expected entry.
  always @(negedge clock) begin
    if (ramWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected: got addr=%h data=%h, expected no write", ramAddr, ramData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ramAddr !== e.addr || ramData !== e.data) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   ramAddr, ramData, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic push_window(input logic [7:0] w, input logic [8:0] h);
    exp_q.push_back({16'd0, 8'd0, w});
    exp_q.push_back({16'd1, 7'd0, h});
    for (int a = 2; a < int'(w) * int'(h) + 2; a++) exp_q.push_back({16'(a), 16'd1});
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pix_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pixelReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Arms a window and counts write cycles until pixelReady rises.
  task automatic arm_window(input logic [7:0] x0, input logic [8:0] y0,
                            input logic [7:0] w, input logic [8:0] h,
                            output int nwr, output bit rdy_ok);
    wait_ready(rdy_ok);
    xOrigin   = x0;
    yOrigin   = y0;
    imgWidth  = w;
    imgHeight = h;
    arm       = 1'b1;
    @(posedge clock);
    #1;
    arm = 1'b0;
    nwr = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (pixelReady === 1'b1) break;
      if (ramWrite === 1'b1) nwr++;
    end
  endtask

  task automatic do_write(input logic [7:0] x, input logic [8:0] y,
                          input logic [15:0] d, output bit ok);
    bit pr;
    wait_pix_ready(pr);
    xAddr      = x;
    yAddr      = y;
    pixelData  = d;
    pixelWrite = 1'b1;
    @(posedge clock);
    #1;
    pixelWrite = 1'b0;
    wait_pix_ready(ok);
    ok = ok && pr;
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({ready, done, error, pixelReady, ramWrite} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000", {ready, done, error, pixelReady, ramWrite});
    end
    checks++;
    if (ramAddr !== 16'd0 || ramData !== 16'd0) begin
      errors++;
      $display("FAIL reset_ram_bus: got addr=%h data=%h, expected 0/0", ramAddr, ramData);
    end
  endtask

  task automatic test_arm_clear;
    int  nwr;
    bit  rdy;
    push_window(8'd4, 9'd3);
    arm_window(8'd10, 9'd20, 8'd4, 9'd3, nwr, rdy);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL arm_ready: ready never rose, expected 1");
    end
    checks++;
    if (nwr != 14 || pixelReady !== 1'b1) begin
      errors++;
      $display("FAIL clear_writes: got %0d writes pixelReady=%b, expected 14 and 1", nwr, pixelReady);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got %b, expected 0", ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_pending: got %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_write_held;
    logic [5:0] exp_pr;
    exp_pr = 6'b110000;
    exp_q.push_back({16'd7, 16'hF800});
    xAddr      = 8'd11;
    yAddr      = 9'd21;
    pixelData  = 16'hF800;
    pixelWrite = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      checks++;
      if (pixelReady !== exp_pr[i]) begin
        errors++;
        $display("FAIL held_pixel_ready[%0d]: got %b, expected %b", i, pixelReady, exp_pr[i]);
      end
      if (i == 4) pixelWrite = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_write: got %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_out_of_window;
    bit ok;
    do_write(8'd9, 9'd20, 16'h1234, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oow_left_handshake: got no completion, expected pixelReady high again");
    end
    do_write(8'd14, 9'd20, 16'h5678, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oow_right_handshake: got no completion, expected pixelReady high again");
    end
    exp_q.push_back({16'd7, 16'h07E0});
    do_write(8'd11, 9'd21, 16'h07E0, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overwrite: got ok=%b pending=%0d, expected ok=1 pending=0", ok, exp_q.size());
    end
  endtask

  task automatic test_finish_during_store;
    bit seen;
    exp_q.push_back({16'd13, 16'hABCD});
    xAddr      = 8'd13;
    yAddr      = 9'd22;
    pixelData  = 16'hABCD;
    pixelWrite = 1'b1;
    @(negedge clock);
    pixelWrite = 1'b0;
    @(posedge clock);
    #1;
    finish = 1'b1;
    @(negedge clock);
    checks++;
    if (ramWrite !== 1'b1 || ramAddr !== 16'd13) begin
      errors++;
      $display("FAIL store_write: got write=%b addr=%h, expected 1 and 000d", ramWrite, ramAddr);
    end
    @(posedge clock);
    #1;
    finish = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || error !== 1'b0) begin
      errors++;
      $display("FAIL finish_done: got done_seen=%b error=%b, expected 1 and 0", seen, error);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got done=%b error=%b, expected 0/0", done, error);
    end
  endtask

  task automatic test_size_error;
    bit rdy;
    wait_ready(rdy);
    xOrigin   = 8'd0;
    yOrigin   = 9'd0;
    imgWidth  = 8'd255;
    imgHeight = 9'd300;
    arm       = 1'b1;
    @(negedge clock);
    checks++;
    if (!rdy || done !== 1'b1 || error !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL size_error: got rdy=%b done=%b error=%b ready=%b, expected 1 1 1 0",
               rdy, done, error, ready);
    end
    arm = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (error !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got done=%b error=%b, expected 0/0", done, error);
    end
  endtask

  task automatic test_reset_during_clear;
    bit rdy;
    int nwr;
    wait_ready(rdy);
    push_window(8'd4, 9'd3);
    xOrigin   = 8'd10;
    yOrigin   = 9'd20;
    imgWidth  = 8'd4;
    imgHeight = 9'd3;
    arm       = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    checks++;
    if ({ready, done, error, pixelReady, ramWrite} !== 5'b0 || ramAddr !== 16'd0 || ramData !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got flags=%b addr=%h data=%h, expected all 0",
               {ready, done, error, pixelReady, ramWrite}, ramAddr, ramData);
    end
    reset = 1'b0;
    push_window(8'd4, 9'd3);
    arm_window(8'd10, 9'd20, 8'd4, 9'd3, nwr, rdy);
    checks++;
    if (!rdy || nwr != 14 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rearm: got rdy=%b writes=%0d pending=%0d, expected 1 14 0", rdy, nwr, exp_q.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    xOrigin    = 8'd0;
    yOrigin    = 9'd0;
    imgWidth   = 8'd0;
    imgHeight  = 9'd0;
    arm        = 1'b0;
    finish     = 1'b0;
    xAddr      = 8'd0;
    yAddr      = 9'd0;
    pixelData  = 16'd0;
    pixelWrite = 1'b0;
    repeat (2) @(posedge clock);
    test_reset;
    @(posedge clock);
    #1;
    reset = 1'b0;
    test_arm_clear;
    test_write_held;
    test_out_of_window;
    test_finish_during_store;
    test_size_error;
    test_reset_during_clear;
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: got %0d writes missing, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
